deserializer: RTL

//  Downstream partner of the serializer: collects N_SAMPLES successive BIT_WIDTH words

---
 rtl/serdes_pkg.sv | 20 ++
 rtl/deserializer_ctrl.sv | 88 ++++++++
 rtl/deserializer.sv | 52 +++++
 3 files changed

// File: rtl/serdes_pkg.sv
// Shared SERDES package: state encoding and sizing helpers used by the
// serializer and deserializer blocks.
package serdes_pkg;

    // Deserializer control states: gathering words, or holding a full frame
    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } deser_state_t;

    // Default link geometry shared by both ends of the link
    localparam int DEFAULT_BIT_WIDTH = 32;
    localparam int DEFAULT_N_SAMPLES = 8;

    // Width of a word index into a frame of n words; never narrower than one bit
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/deserializer_ctrl.sv
// Deserializer control: COLLECT/FULL state machine plus the word index counter.
// Produces the write strobe and write slot for the frame register array and
// the two handshake outputs. Optional feature macro: DESERIALIZER_OVERLAP_EN
// (when defined, a new frame may start on the same cycle the old one leaves).
module deserializer_ctrl
    import serdes_pkg::*;
#(
    parameter  int N_SAMPLES = DEFAULT_N_SAMPLES,
    localparam int IW        = idx_width(N_SAMPLES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          recv_val,
    input  logic          send_rdy,
    output logic          wr_en,
    output logic [IW-1:0] wr_idx,
    output logic          send_val,
    output logic          recv_rdy
);

    localparam logic [IW-1:0] LAST_IDX = IW'(N_SAMPLES - 1);

    deser_state_t  state;
    deser_state_t  state_nxt;
    logic [IW-1:0] idx;
    logic [IW-1:0] idx_nxt;

    // State and index registers; reset drops any partial frame
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= COLLECT;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Next-state, index update and handshake decodes
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        wr_en     = 1'b0;
        wr_idx    = idx;
        send_val  = 1'b0;
        recv_rdy  = 1'b0;
        case (state)
            COLLECT: begin
                recv_rdy = 1'b1;
                if (recv_val) begin
                    wr_en = 1'b1;
                    if (idx == LAST_IDX) begin
                        idx_nxt   = '0;
                        state_nxt = FULL;
                    end else begin
                        idx_nxt = idx + IW'(1);
                    end
                end
            end
            FULL: begin
                send_val = 1'b1;
`ifdef DESERIALIZER_OVERLAP_EN
                // Accept word 0 of the next frame only when the current one leaves
                recv_rdy = send_rdy;
                if (send_rdy) begin
                    state_nxt = COLLECT;
                    if (recv_val) begin
                        wr_en   = 1'b1;
                        wr_idx  = '0;
                        idx_nxt = IW'(1);
                    end
                end
`else
                // Input stalls while the frame waits; costs one dead cycle per frame
                recv_rdy = 1'b0;
                if (send_rdy) begin
                    state_nxt = COLLECT;
                end
`endif
            end
            default: begin
                state_nxt = COLLECT;
                idx_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/deserializer.sv
// Deserializer top: gathers N_SAMPLES words from a val/rdy stream into one
// parallel frame; word k of a frame lands in send_msg[k]. Optional feature
// macro: DESERIALIZER_OVERLAP_EN (full-rate overlap of send and receive).
module deserializer
    import serdes_pkg::*;
#(
    parameter  int BIT_WIDTH = DEFAULT_BIT_WIDTH,
    parameter  int N_SAMPLES = DEFAULT_N_SAMPLES,
    localparam int IW        = idx_width(N_SAMPLES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BIT_WIDTH-1:0] recv_msg,
    input  logic                 recv_val,
    output logic                 recv_rdy,
    output logic [BIT_WIDTH-1:0] send_msg [N_SAMPLES-1:0],
    output logic                 send_val,
    input  logic                 send_rdy
);

    logic          wr_en;
    logic [IW-1:0] wr_idx;

    deserializer_ctrl #(
        .N_SAMPLES (N_SAMPLES)
    ) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .recv_val (recv_val),
        .send_rdy (send_rdy),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .send_val (send_val),
        .recv_rdy (recv_rdy)
    );

    // Frame register array; a slot changes only when the controller writes it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < N_SAMPLES; k++) begin
                send_msg[k] <= '0;
            end
        end else if (wr_en) begin
            for (int k = 0; k < N_SAMPLES; k++) begin
                if (wr_idx == IW'(k)) begin
                    send_msg[k] <= recv_msg;
                end
            end
        end
    end

endmodule
